psm_phase_scheduler: RTL and testbench

//  Phase-shift scheduler feeding the PSM deadtime stages. Generates two 50%-duty
//  leg commands (leg A, leg B) from a programmable period and phase shift.

---
 rtl/psm_phase_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_psm_phase_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/psm_phase_scheduler.sv
// psm_phase_scheduler
// Phase-shift scheduler for the PSM deadtime stages. Produces two 50%-duty leg
// commands from a programmable period and leg-B lag, and forwards the active
// deadtime/period. Settings are double-buffered and only take effect at a
// period boundary (or at once while idle), so a leg never sees a torn period.
// Optional build macro: PSM_SCHED_SOFTSTART_EN (soft-start phase ramp).

module psm_phase_scheduler #(
  parameter int CNT_W      = 16,
  parameter int SHIFT_W    = 7,
  parameter int MIN_PERIOD = 4
`ifdef PSM_SCHED_SOFTSTART_EN
  ,
  parameter int SS_STEP    = 1
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [CNT_W-1:0]   i_phase,
  input  logic [SHIFT_W-1:0] i_dead,
  output logic               o_cfg_err,
  output logic               o_psm_a,
  output logic               o_psm_b,
  output logic [SHIFT_W-1:0] o_dead,
  output logic [CNT_W-1:0]   o_period,
  output logic               o_sync,
  output logic               o_running
);

  localparam logic [CNT_W-1:0]   MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]   ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   ZERO   = {CNT_W{1'b0}};
  localparam logic [SHIFT_W-1:0] DZERO  = {SHIFT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   act_period_r;
  logic [SHIFT_W-1:0] act_dead_r;
  logic [CNT_W-1:0]   work_ph_r;
  logic [CNT_W-1:0]   sh_period_r;
  logic [CNT_W-1:0]   sh_phase_r;
  logic [SHIFT_W-1:0] sh_dead_r;
  logic               pending_r;
  logic               ready_r;
  logic               cfg_err_r;
  logic               psm_a_r;
  logic               psm_b_r;
  logic               sync_r;
  logic               running_r;

  logic               running_s;
  logic               accept_s;
  logic               cfg_bad_s;
  logic               wrap_s;
  logic               apply_s;
  logic               start_s;
  logic [CNT_W-1:0]   ph_eff_s;
  logic [CNT_W-1:0]   half_s;
  logic [CNT_W-1:0]   cnt_b_s;
  logic               leg_a_s;
  logic               leg_b_s;
  logic [CNT_W-1:0]   work_nxt_s;

`ifdef PSM_SCHED_SOFTSTART_EN
  localparam int CW1 = CNT_W + 1;
  logic [CNT_W-1:0]   tgt_ph_r;
  logic [CNT_W-1:0]   tgt_nxt_s;
  logic [CNT_W:0]     ss_inc_s;
`endif

  // Period timing, handshake qualifiers and leg decode for the current count
  always_comb begin
    running_s = (state_r == ST_RUN) || (state_r == ST_STOP);
    accept_s  = i_cfg_valid && ready_r;
    cfg_bad_s = (i_period < MIN_P);
    wrap_s    = running_s && (cnt_r == (act_period_r - ONE));
    apply_s   = pending_r && ((state_r == ST_IDLE) || wrap_s);
    start_s   = (state_r == ST_IDLE) && i_enable && (act_period_r >= MIN_P);
    if (sh_phase_r > (sh_period_r - ONE)) begin
      ph_eff_s = sh_period_r - ONE;
    end else begin
      ph_eff_s = sh_phase_r;
    end
    half_s = act_period_r >> 1;
    // ph <= P-1 always, so cnt+P-ph stays inside CNT_W bits
    if (cnt_r >= work_ph_r) begin
      cnt_b_s = cnt_r - work_ph_r;
    end else begin
      cnt_b_s = cnt_r + act_period_r - work_ph_r;
    end
    leg_a_s = running_s && (cnt_r < half_s);
    leg_b_s = running_s && (cnt_b_s < half_s);
  end

`ifdef PSM_SCHED_SOFTSTART_EN
  // Working phase ramps toward the target one step per wrap; drops apply at once
  always_comb begin
    tgt_nxt_s = apply_s ? ph_eff_s : tgt_ph_r;
    ss_inc_s  = {1'b0, work_ph_r} + CW1'(SS_STEP);
    if (start_s) begin
      work_nxt_s = ZERO;
    end else if (tgt_nxt_s < work_ph_r) begin
      work_nxt_s = tgt_nxt_s;
    end else if (wrap_s) begin
      if (ss_inc_s > {1'b0, tgt_nxt_s}) begin
        work_nxt_s = tgt_nxt_s;
      end else begin
        work_nxt_s = ss_inc_s[CNT_W-1:0];
      end
    end else begin
      work_nxt_s = work_ph_r;
    end
  end
`else
  // Working phase is the clamped phase, taken at apply
  always_comb begin
    if (apply_s) begin
      work_nxt_s = ph_eff_s;
    end else begin
      work_nxt_s = work_ph_r;
    end
  end
`endif

  // Config handshake, shadow buffer and transfer to the active settings
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_period_r  <= ZERO;
      sh_phase_r   <= ZERO;
      sh_dead_r    <= DZERO;
      pending_r    <= 1'b0;
      ready_r      <= 1'b1;
      cfg_err_r    <= 1'b0;
      act_period_r <= ZERO;
      act_dead_r   <= DZERO;
      work_ph_r    <= ZERO;
`ifdef PSM_SCHED_SOFTSTART_EN
      tgt_ph_r     <= ZERO;
`endif
    end else begin
      cfg_err_r <= accept_s && cfg_bad_s;
      if (accept_s && !cfg_bad_s) begin
        sh_period_r <= i_period;
        sh_phase_r  <= i_phase;
        sh_dead_r   <= i_dead;
        pending_r   <= 1'b1;
        ready_r     <= 1'b0;
      end else if (apply_s) begin
        // ready comes back one cycle after the transfer
        pending_r <= 1'b0;
        ready_r   <= 1'b0;
      end else begin
        ready_r <= !pending_r;
      end
      if (apply_s) begin
        act_period_r <= sh_period_r;
        act_dead_r   <= sh_dead_r;
      end
      work_ph_r <= work_nxt_s;
`ifdef PSM_SCHED_SOFTSTART_EN
      tgt_ph_r  <= tgt_nxt_s;
`endif
    end
  end

  // Run/stop sequencing and the period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= ZERO;
          if (start_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt_r <= wrap_s ? ZERO : cnt_r + ONE;
          if (i_enable) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          cnt_r <= wrap_s ? ZERO : cnt_r + ONE;
          if (i_enable) begin
            state_r <= ST_RUN;
          end else if (wrap_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_STOP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= ZERO;
        end
      endcase
    end
  end

  // Registered leg commands and status, one cycle behind the decoded count
  always_ff @(posedge clk) begin
    if (rst) begin
      psm_a_r   <= 1'b0;
      psm_b_r   <= 1'b0;
      sync_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      psm_a_r   <= leg_a_s;
      psm_b_r   <= leg_b_s;
      sync_r    <= running_s && (cnt_r == ZERO);
      running_r <= running_s;
    end
  end

  assign o_cfg_ready = ready_r;
  assign o_cfg_err   = cfg_err_r;
  assign o_psm_a     = psm_a_r;
  assign o_psm_b     = psm_b_r;
  assign o_dead      = act_dead_r;
  assign o_period    = act_period_r;
  assign o_sync      = sync_r;
  assign o_running   = running_r;

endmodule

// File: tb/tb_psm_phase_scheduler.sv
// tb_psm_phase_scheduler
// Directed scenarios followed by randomized config/enable/reset traffic, every
// output checked each cycle against a behavioural model built from
// period-position arithmetic (position modulo P, lag modulo P).

module tb_psm_phase_scheduler;

  localparam int MIN_PERIOD = 4;
`ifdef PSM_SCHED_SOFTSTART_EN
  localparam int SS_STEP = 1;
`endif

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [15:0] i_period;
  logic [15:0] i_phase;
  logic [6:0]  i_dead;
  logic        o_cfg_err;
  logic        o_psm_a;
  logic        o_psm_b;
  logic [6:0]  o_dead;
  logic [15:0] o_period;
  logic        o_sync;
  logic        o_running;

  int n_checks;
  int n_errors;

  // model state: mode 0 idle / 1 run / 2 stop, position inside the period
  int m_mode, m_pos, m_P, m_ph, m_dead, m_pend, m_sP, m_sph, m_sdead;
`ifdef PSM_SCHED_SOFTSTART_EN
  int m_tgt;
`endif
  int e_a, e_b, e_sync, e_run, e_err, e_ready;

  psm_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_period    (i_period),
    .i_phase     (i_phase),
    .i_dead      (i_dead),
    .o_cfg_err   (o_cfg_err),
    .o_psm_a     (o_psm_a),
    .o_psm_b     (o_psm_b),
    .o_dead      (o_dead),
    .o_period    (o_period),
    .o_sync      (o_sync),
    .o_running   (o_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // advance the model across one clock edge using the inputs presently driven
  task automatic model_edge();
    int wrap, apply, start, acc, eff;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_P = 0; m_ph = 0; m_dead = 0;
      m_pend = 0; m_sP = 0; m_sph = 0; m_sdead = 0;
`ifdef PSM_SCHED_SOFTSTART_EN
      m_tgt = 0;
`endif
      e_a = 0; e_b = 0; e_sync = 0; e_run = 0; e_err = 0; e_ready = 1;
    end else begin
      if (m_mode != 0) begin
        e_a    = (m_pos < m_P / 2) ? 1 : 0;
        e_b    = (((m_pos - m_ph + m_P) % m_P) < m_P / 2) ? 1 : 0;
        e_sync = (m_pos == 0) ? 1 : 0;
        e_run  = 1;
      end else begin
        e_a = 0; e_b = 0; e_sync = 0; e_run = 0;
      end
      acc   = (i_cfg_valid && e_ready != 0) ? 1 : 0;
      e_err = (acc != 0 && int'(i_period) < MIN_PERIOD) ? 1 : 0;
      wrap  = (m_mode != 0 && m_pos == m_P - 1) ? 1 : 0;
      apply = (m_pend != 0 && (m_mode == 0 || wrap != 0)) ? 1 : 0;
      start = (m_mode == 0 && i_enable && m_P >= MIN_PERIOD) ? 1 : 0;
      if (m_mode == 0) begin
        m_pos = 0;
        if (start != 0) m_mode = 1;
      end else begin
        m_pos = (m_pos + 1) % m_P;
        if (m_mode == 1) begin
          if (!i_enable) m_mode = 2;
        end else if (i_enable) begin
          m_mode = 1;
        end else if (wrap != 0) begin
          m_mode = 0;
        end
      end
      eff = 0;
      if (apply != 0) begin
        eff    = (m_sph > m_sP - 1) ? m_sP - 1 : m_sph;
        m_P    = m_sP;
        m_dead = m_sdead;
        m_pend = 0;
`ifndef PSM_SCHED_SOFTSTART_EN
        m_ph   = eff;
`endif
      end
`ifdef PSM_SCHED_SOFTSTART_EN
      if (apply != 0) m_tgt = eff;
      if (start != 0) m_ph = 0;
      else if (m_tgt < m_ph) m_ph = m_tgt;
      else if (wrap != 0) m_ph = (m_ph + SS_STEP > m_tgt) ? m_tgt : m_ph + SS_STEP;
`endif
      if (acc != 0 && e_err == 0) begin
        m_pend  = 1;
        m_sP    = int'(i_period);
        m_sph   = int'(i_phase);
        m_sdead = int'(i_dead);
      end
      e_ready = (m_pend == 0 && apply == 0) ? 1 : 0;
    end
  endtask

  // one clock: model, edge, then compare everything away from the edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_val("psm_a",   32'(o_psm_a),     32'(e_a));
    check_val("psm_b",   32'(o_psm_b),     32'(e_b));
    check_val("sync",    32'(o_sync),      32'(e_sync));
    check_val("running", 32'(o_running),   32'(e_run));
    check_val("cfg_err", 32'(o_cfg_err),   32'(e_err));
    check_val("ready",   32'(o_cfg_ready), 32'(e_ready));
    check_val("period",  32'(o_period),    32'(m_P));
    check_val("dead",    32'(o_dead),      32'(m_dead));
  endtask

  task automatic send_cfg(input int p, input int ph, input int d);
    i_cfg_valid = 1'b1;
    i_period    = 16'(p);
    i_phase     = 16'(ph);
    i_dead      = 7'(d);
    step();
    i_cfg_valid = 1'b0;
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < 64 && !(m_mode != 0 && m_pos == p); k++) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mode = 0; m_pos = 0; m_P = 0; m_ph = 0; m_dead = 0;
    m_pend = 0; m_sP = 0; m_sph = 0; m_sdead = 0;
`ifdef PSM_SCHED_SOFTSTART_EN
    m_tgt = 0;
`endif
    e_a = 0; e_b = 0; e_sync = 0; e_run = 0; e_err = 0; e_ready = 1;
    rst = 1'b1; i_enable = 1'b0; i_cfg_valid = 1'b0;
    i_period = 16'd0; i_phase = 16'd0; i_dead = 7'd0;
    repeat (2) step();
    rst = 1'b0;

    // enable without any configuration stays idle
    i_enable = 1'b1;
    repeat (4) step();
    i_enable = 1'b0;

    // P=8 ph=2 dead=3, then run
    send_cfg(8, 2, 3);
    repeat (3) step();
    i_enable = 1'b1;
    repeat (20) step();

    // rejected short period
    send_cfg(3, 0, 5);
    repeat (3) step();

    // new period requested mid-run
    run_to_pos(3);
    send_cfg(12, 2, 4);
    repeat (30) step();

    // stop mid-period, then re-enable before the wrap
    run_to_pos(2);
    i_enable = 1'b0;
    repeat (20) step();
    i_enable = 1'b1;
    repeat (3) step();
    run_to_pos(2);
    i_enable = 1'b0;
    run_to_pos(5);
    i_enable = 1'b1;
    repeat (20) step();

    // phase clamp: ph=20 on P=8
    i_enable = 1'b0;
    repeat (24) step();
    send_cfg(8, 20, 2);
    i_enable = 1'b1;
    repeat (20) step();

    // odd period
    send_cfg(5, 1, 9);
    repeat (20) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      i_cfg_valid = ($urandom_range(0, 5) == 0);
      i_period    = 16'($urandom_range(1, 20));
      i_phase     = 16'($urandom_range(0, 25));
      i_dead      = 7'($urandom);
      if ($urandom_range(0, 24) == 0) i_enable = !i_enable;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    i_cfg_valid = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
